// File: rtl/score_ctrl.sv
// score_ctrl: synchronised, debounced four-button scoreboard with PLAY/OVER game state.
// Winner-digit blink in OVER is built only when SCORE_BLINK_EN is defined.
//
// state   | meaning
// ST_PLAY | scores follow accepted button presses
// ST_OVER | a team reached WIN_SCORE; scores frozen until the next press
module score_ctrl #(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int BLINK_CYCLES    = 25_000_000,
  parameter int WIN_SCORE       = 21
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  btn,
  output logic [15:0] num,
  output logic [3:0]  le,
  output logic [3:0]  point,
  output logic [1:0]  winner,
  output logic        game_over
);

  typedef enum logic {ST_PLAY = 1'b0, ST_OVER = 1'b1} state_t;

  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [DW-1:0] DB_LAST = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [7:0] WIN_BCD = {4'(WIN_SCORE / 10), 4'(WIN_SCORE % 10)};

  if (DEBOUNCE_CYCLES < 2 || BLINK_CYCLES < 1 || WIN_SCORE < 1 || WIN_SCORE > 99) begin : g_param_check
    $error("score_ctrl: parameter out of range");
  end

  logic [3:0]    sync1_q, sync2_q;
  logic [3:0]    acc_q, acc_d;
  logic [3:0]    press_q, press_d;
  logic [DW-1:0] db_cnt_q [4];
  logic [DW-1:0] db_cnt_d [4];

  state_t     state_q, state_d;
  logic [7:0] a_q, a_d, b_q, b_d;
  logic [1:0] win_q, win_d;
  logic [3:0] le_q, le_d, point_q, point_d;
  logic       over_q;
  logic       phase_d;
  logic       a_up, a_dn, b_up, b_dn, a_hit, b_hit;

  function automatic logic [7:0] bcd_inc(input logic [7:0] v);
    if (v == 8'h99) return v;
    if (v[3:0] == 4'd9) return {v[7:4] + 4'd1, 4'd0};
    return {v[7:4], v[3:0] + 4'd1};
  endfunction

  function automatic logic [7:0] bcd_dec(input logic [7:0] v);
    if (v == 8'h00) return v;
    if (v[3:0] == 4'd0) return {v[7:4] - 4'd1, 4'd9};
    return {v[7:4], v[3:0] - 4'd1};
  endfunction

  // Counter runs only while the synchronised level disagrees with the accepted one.
  always_comb begin
    acc_d = acc_q;
    for (int i = 0; i < 4; i++) begin
      db_cnt_d[i] = '0;
      if (sync2_q[i] != acc_q[i]) begin
        if (db_cnt_q[i] == DB_LAST) acc_d[i] = sync2_q[i];
        else db_cnt_d[i] = db_cnt_q[i] + DW'(1);
      end
    end
    press_d = acc_d & ~acc_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
      acc_q   <= '0;
      press_q <= '0;
      for (int i = 0; i < 4; i++) db_cnt_q[i] <= '0;
    end else begin
      sync1_q <= btn;
      sync2_q <= sync1_q;
      acc_q   <= acc_d;
      press_q <= press_d;
      for (int i = 0; i < 4; i++) db_cnt_q[i] <= db_cnt_d[i];
    end
  end

  assign a_up = press_q[0] & ~press_q[1];
  assign a_dn = press_q[1] & ~press_q[0];
  assign b_up = press_q[2] & ~press_q[3];
  assign b_dn = press_q[3] & ~press_q[2];

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    win_d   = win_q;
    a_hit   = 1'b0;
    b_hit   = 1'b0;
    case (state_q)
      ST_PLAY: begin
        if (a_up) a_d = bcd_inc(a_q);
        else if (a_dn) a_d = bcd_dec(a_q);
        if (b_up) b_d = bcd_inc(b_q);
        else if (b_dn) b_d = bcd_dec(b_q);
        a_hit = (a_d != a_q) && (a_d == WIN_BCD);
        b_hit = (b_d != b_q) && (b_d == WIN_BCD);
        if (a_hit || b_hit) begin
          state_d = ST_OVER;
          win_d   = {a_hit, b_hit};
        end
      end
      ST_OVER: begin
        // The restarting press is consumed here and never scores.
        if (|press_q) begin
          state_d = ST_PLAY;
          a_d     = '0;
          b_d     = '0;
          win_d   = '0;
        end
      end
      default: state_d = ST_PLAY;
    endcase
  end

  always_comb begin
    le_d    = {a_d[7:4] == 4'd0, 1'b0, b_d[7:4] == 4'd0, 1'b0};
    point_d = {1'b0, a_d > b_d, 1'b0, b_d > a_d};
    if (state_d == ST_OVER) begin
      point_d   = '0;
      le_d[3:2] = win_d[1] ? {2{phase_d}} : 2'b11;
      le_d[1:0] = win_d[0] ? {2{phase_d}} : 2'b11;
    end
  end

`ifdef SCORE_BLINK_EN
  localparam int BW = (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;
  localparam logic [BW-1:0] BL_LAST = BW'(BLINK_CYCLES - 1);

  logic [BW-1:0] blink_cnt_q, blink_cnt_d;
  logic          phase_q;

  // Counting starts the cycle after entry so phase 0 lasts a full BLINK_CYCLES.
  always_comb begin
    blink_cnt_d = '0;
    phase_d     = 1'b0;
    if (state_d == ST_OVER) begin
      blink_cnt_d = blink_cnt_q;
      phase_d     = phase_q;
      if (state_q == ST_OVER) begin
        if (blink_cnt_q == BL_LAST) begin
          blink_cnt_d = '0;
          phase_d     = ~phase_q;
        end else begin
          blink_cnt_d = blink_cnt_q + BW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      blink_cnt_q <= '0;
      phase_q     <= 1'b0;
    end else begin
      blink_cnt_q <= blink_cnt_d;
      phase_q     <= phase_d;
    end
  end
`else
  assign phase_d = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_PLAY;
      a_q     <= '0;
      b_q     <= '0;
      win_q   <= '0;
      le_q    <= 4'b1010;
      point_q <= '0;
      over_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      win_q   <= win_d;
      le_q    <= le_d;
      point_q <= point_d;
      over_q  <= (state_d == ST_OVER);
    end
  end

  assign num       = {a_q, b_q};
  assign le        = le_q;
  assign point     = point_q;
  assign winner    = win_q;
  assign game_over = over_q;

endmodule

// File: tb/tb_score_ctrl.sv
// Scoreboard bench for score_ctrl: decimal reference model feeds an expected-output queue.
module tb_score_ctrl;
  localparam int DB = 4;
  localparam int BL = 8;
  localparam int WS = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  btn;
  logic [15:0] num;
  logic [3:0]  le, point;
  logic [1:0]  winner;
  logic        game_over;
  logic [26:0] obs;
  logic [26:0] expv;
  logic [26:0] exp_q[$];

  int total = 0;
  int bad = 0;
  int ma, mb;
  logic mover;
  logic [1:0] mwin;

  always #5 clk = ~clk;

  score_ctrl #(.DEBOUNCE_CYCLES(DB), .BLINK_CYCLES(BL), .WIN_SCORE(WS)) dut (
    .clk(clk), .rst(rst), .btn(btn), .num(num), .le(le), .point(point),
    .winner(winner), .game_over(game_over)
  );

  assign obs = {num, le, point, winner, game_over};

  function automatic logic [7:0] to_bcd(input int v);
    return 8'(((v / 10) << 4) | (v % 10));
  endfunction

  function automatic logic [26:0] model_vec();
    logic [3:0] l, p;
    if (!mover) begin
      l = {ma < 10, 1'b0, mb < 10, 1'b0};
      p = {1'b0, ma > mb, 1'b0, mb > ma};
    end else begin
      l = {~mwin[1], ~mwin[1], ~mwin[0], ~mwin[0]};
      p = 4'b0000;
    end
    return {to_bcd(ma), to_bcd(mb), l, p, mwin, mover};
  endfunction

  task automatic model_press(input logic [3:0] m);
    int na, nb;
    if (mover) begin
      if (m != 4'b0000) begin
        ma = 0; mb = 0; mover = 1'b0; mwin = 2'b00;
      end
    end else begin
      na = ma + int'(m[0] && !m[1]) - int'(m[1] && !m[0]);
      nb = mb + int'(m[2] && !m[3]) - int'(m[3] && !m[2]);
      if (na > 99) na = 99;
      if (na < 0) na = 0;
      if (nb > 99) nb = 99;
      if (nb < 0) nb = 0;
      mwin = {(na != ma) && (na == WS), (nb != mb) && (nb == WS)};
      ma = na;
      mb = nb;
      mover = (mwin != 2'b00);
    end
    exp_q.push_back(model_vec());
  endtask

  task automatic do_reset();
    btn = 4'b0000;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    ma = 0; mb = 0; mover = 1'b0; mwin = 2'b00;
    exp_q.delete();
    exp_q.push_back(model_vec());
  endtask

  task automatic drive_press(input logic [3:0] m);
    model_press(m);
    btn = m;
    repeat (DB + 3) @(negedge clk);
  endtask

  task automatic release_btns();
    btn = 4'b0000;
    repeat (DB + 4) @(negedge clk);
  endtask

  task automatic test_reset();
    do_reset();
    expv = exp_q.pop_front(); total++;
    if (obs !== expv) begin bad++; $display("FAIL reset_state: got %h want %h", obs, expv); end
    repeat (5) @(negedge clk);
    exp_q.push_back(model_vec());
    expv = exp_q.pop_front(); total++;
    if (obs !== expv) begin bad++; $display("FAIL reset_idle: got %h want %h", obs, expv); end
    btn = 4'b0001;
    repeat (DB - 1) @(negedge clk);
    btn = 4'b0000;
    repeat (10) @(negedge clk);
    exp_q.push_back(model_vec());
    expv = exp_q.pop_front(); total++;
    if (obs !== expv) begin bad++; $display("FAIL short_glitch: got %h want %h", obs, expv); end
  endtask

  task automatic test_saturation();
    drive_press(4'b0010);
    expv = exp_q.pop_front(); total++;
    if (obs !== expv) begin bad++; $display("FAIL a_dec_at_zero: got %h want %h", obs, expv); end
    release_btns();
    drive_press(4'b1000);
    expv = exp_q.pop_front(); total++;
    if (obs !== expv) begin bad++; $display("FAIL b_dec_at_zero: got %h want %h", obs, expv); end
    release_btns();
  endtask

  task automatic test_latency();
    model_press(4'b0001);
    btn = 4'b0001;
    repeat (DB + 2) @(negedge clk);
    total++;
    if (num !== 16'h0000) begin bad++; $display("FAIL early_event: got num=%h want 0000", num); end
    @(negedge clk);
    expv = exp_q.pop_front(); total++;
    if (obs !== expv) begin bad++; $display("FAIL press_latency: got %h want %h", obs, expv); end
    repeat (3) @(negedge clk);
    release_btns();
    exp_q.push_back(model_vec());
    expv = exp_q.pop_front(); total++;
    if (obs !== expv) begin bad++; $display("FAIL single_event_on_hold: got %h want %h", obs, expv); end
  endtask

  task automatic test_same_cycle();
    drive_press(4'b0011);
    expv = exp_q.pop_front(); total++;
    if (obs !== expv) begin bad++; $display("FAIL a_inc_dec_cancel: got %h want %h", obs, expv); end
    release_btns();
    drive_press(4'b0001);
    expv = exp_q.pop_front(); total++;
    if (obs !== expv) begin bad++; $display("FAIL a_to_two: got %h want %h", obs, expv); end
    release_btns();
    drive_press(4'b0110);
    expv = exp_q.pop_front(); total++;
    if (obs !== expv) begin bad++; $display("FAIL cross_team: got %h want %h", obs, expv); end
    release_btns();
  endtask

  task automatic test_win_blink();
    logic [3:0] exp_le;
    do_reset();
    expv = exp_q.pop_front(); total++;
    if (obs !== expv) begin bad++; $display("FAIL reset_before_win: got %h want %h", obs, expv); end
    for (int n = 0; n < 2; n++) begin
      drive_press(4'b0100);
      expv = exp_q.pop_front(); total++;
      if (obs !== expv) begin bad++; $display("FAIL b_climb%0d: got %h want %h", n, obs, expv); end
      release_btns();
    end
    drive_press(4'b0100);
    expv = exp_q.pop_front(); total++;
    if (obs !== expv) begin bad++; $display("FAIL b_wins: got %h want %h", obs, expv); end
    for (int k = 1; k < 3 * BL; k++) begin
      @(negedge clk);
`ifdef SCORE_BLINK_EN
      exp_le = (((k / BL) % 2) == 1) ? 4'b1111 : 4'b1100;
`else
      exp_le = 4'b1100;
`endif
      total++;
      if (le !== exp_le || num !== 16'h0003) begin
        bad++; $display("FAIL over_le k=%0d: got le=%b num=%h want le=%b num=0003", k, le, num, exp_le);
      end
    end
    release_btns();
    drive_press(4'b1000);
    expv = exp_q.pop_front(); total++;
    if (obs !== expv) begin bad++; $display("FAIL restart_press: got %h want %h", obs, expv); end
    release_btns();
  endtask

  task automatic test_both_win();
    logic [3:0] seq [4];
    seq[0] = 4'b0001; seq[1] = 4'b0001; seq[2] = 4'b0100; seq[3] = 4'b0100;
    for (int n = 0; n < 4; n++) begin
      drive_press(seq[n]);
      expv = exp_q.pop_front(); total++;
      if (obs !== expv) begin bad++; $display("FAIL tie_build%0d: got %h want %h", n, obs, expv); end
      release_btns();
    end
    drive_press(4'b0101);
    expv = exp_q.pop_front(); total++;
    if (obs !== expv) begin bad++; $display("FAIL both_win: got %h want %h", obs, expv); end
    release_btns();
    drive_press(4'b0010);
    expv = exp_q.pop_front(); total++;
    if (obs !== expv) begin bad++; $display("FAIL restart_after_tie: got %h want %h", obs, expv); end
    release_btns();
  endtask

  task automatic test_reset_mid();
    drive_press(4'b0001);
    expv = exp_q.pop_front(); total++;
    if (obs !== expv) begin bad++; $display("FAIL pre_reset_score: got %h want %h", obs, expv); end
    release_btns();
    btn = 4'b0001;
    repeat (3) @(negedge clk);
    do_reset();
    expv = exp_q.pop_front(); total++;
    if (obs !== expv) begin bad++; $display("FAIL reset_mid_debounce: got %h want %h", obs, expv); end
    repeat (12) @(negedge clk);
    exp_q.push_back(model_vec());
    expv = exp_q.pop_front(); total++;
    if (obs !== expv) begin bad++; $display("FAIL no_stale_event: got %h want %h", obs, expv); end
    for (int n = 0; n < 3; n++) begin
      drive_press(4'b0001);
      expv = exp_q.pop_front(); total++;
      if (obs !== expv) begin bad++; $display("FAIL a_climb%0d: got %h want %h", n, obs, expv); end
      if (n < 2) release_btns();
    end
    repeat (10) @(negedge clk);
    do_reset();
    expv = exp_q.pop_front(); total++;
    if (obs !== expv) begin bad++; $display("FAIL reset_in_over: got %h want %h", obs, expv); end
    repeat (12) @(negedge clk);
    exp_q.push_back(model_vec());
    expv = exp_q.pop_front(); total++;
    if (obs !== expv) begin bad++; $display("FAIL idle_after_over_reset: got %h want %h", obs, expv); end
  endtask

  initial begin
    rst = 1'b1;
    btn = 4'b0000;
    ma = 0; mb = 0; mover = 1'b0; mwin = 2'b00;
    test_reset();
    test_saturation();
    test_latency();
    test_same_cycle();
    test_win_blink();
    test_both_win();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
